// File: rtl/uart_tx_engine.sv
// uart_tx_engine: serializes one character per accepted load into an
// 11-bit-time asynchronous frame (start, 7/8 data LSB first, optional parity,
// stop bits) on tx.
// Ports:
//   clk, rst      - system clock, synchronous active-high reset
//   load          - one-cycle write strobe, accepted only while txrdy=1
//   out_port[7:0] - character to send
//   eight         - 1 = 8 data bits, 0 = 7 data bits
//   pen, ohel     - parity enable, odd(1)/even(0) parity select
//   tx            - serial line (registered, idles high)
//   txrdy         - registered ready flag, high while idle
module uart_tx_engine #(
  parameter int unsigned BAUD_DIV = 10416
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] out_port,
  input  logic       eight,
  input  logic       pen,
  input  logic       ohel,
  output logic       tx,
  output logic       txrdy
);

  localparam int unsigned CNT_W   = $clog2(BAUD_DIV);
  localparam int unsigned FRAME_W = 11;
  localparam int unsigned BIT_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [FRAME_W-1:0]   shift_q, shift_d;
  logic [7:0]           data_q, data_d;
  logic                 eight_q, eight_d;
  logic                 pen_q, pen_d;
  logic                 ohel_q, ohel_d;
  logic                 txrdy_q, txrdy_d;

  logic                 parity_c;
  logic                 par_bit_c;
  logic [FRAME_W-1:0]   frame_c;

  // Frame assembly from the configuration captured at load time.
  always_comb begin
    parity_c  = (eight_q ? (^data_q) : (^data_q[6:0])) ^ ohel_q;
    par_bit_c = pen_q ? parity_c : 1'b1;
    frame_c   = {1'b1,
                 eight_q ? par_bit_c : 1'b1,
                 eight_q ? data_q[7] : par_bit_c,
                 data_q[6:0],
                 1'b0};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    eight_d = eight_q;
    pen_d   = pen_q;
    ohel_d  = ohel_q;
    txrdy_d = txrdy_q;

    case (state_q)
      IDLE: begin
        txrdy_d = 1'b1;
        if (load) begin
          data_d  = out_port;
          eight_d = eight;
          pen_d   = pen;
          ohel_d  = ohel;
          txrdy_d = 1'b0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        shift_d = frame_c;
        baud_d  = '0;
        bit_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (baud_q == CNT_W'(BAUD_DIV - 1)) begin
          // After the 11th shift the register is all ones, so tx idles high.
          baud_d  = '0;
          shift_d = {1'b1, shift_q[FRAME_W-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(FRAME_W - 1)) begin
            txrdy_d = 1'b1;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        txrdy_d = 1'b1;
        shift_d = '1;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '1;
      data_q  <= '0;
      eight_q <= 1'b0;
      pen_q   <= 1'b0;
      ohel_q  <= 1'b0;
      txrdy_q <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      eight_q <= eight_d;
      pen_q   <= pen_d;
      ohel_q  <= ohel_d;
      txrdy_q <= txrdy_d;
    end
  end

  // tx comes straight from the shift register flop.
  assign tx    = shift_q[0];
  assign txrdy = txrdy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Testbench for uart_tx_engine with BAUD_DIV=4. Expected frames are queued
// when a character is offered and popped when the captured frame completes.
module tb_uart_tx_engine;

  localparam int unsigned BAUD = 4;

  logic       clk;
  logic       rst;
  logic       load;
  logic [7:0] out_port;
  logic       eight;
  logic       pen;
  logic       ohel;
  logic       tx;
  logic       txrdy;

  int checks;
  int failures;

  logic [10:0] exp_q[$];

  uart_tx_engine #(.BAUD_DIV(BAUD)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .out_port (out_port),
    .eight    (eight),
    .pen      (pen),
    .ohel     (ohel),
    .tx       (tx),
    .txrdy    (txrdy)
  );

  always #5 clk = ~clk;

  // Offers one character and records the frame; bit i of bits is frame index i,
  // sampled at E1 + 4i + 2. low is the number of cycles txrdy stayed low.
  // Optional extra load (0xFF) or reset is injected at cycle offset from E0.
  task automatic run_frame(input logic [7:0] d, input logic e, input logic p,
                           input logic o, input int load_at, input int rst_at,
                           output logic [10:0] bits, output int low,
                           output logic tx_e1);
    int cyc;
    int idx;
    out_port = d; eight = e; pen = p; ohel = o; load = 1'b1;
    @(posedge clk); #1;
    load  = 1'b0;
    cyc   = 0;
    idx   = 0;
    bits  = '1;
    tx_e1 = 1'b1;
    while (txrdy === 1'b0 && cyc < 200) begin
      if (cyc == 1) tx_e1 = tx;
      if (cyc >= 3 && idx < 11 && ((cyc - 3) % int'(BAUD)) == 0) begin
        bits[idx] = tx;
        idx++;
      end
      if (cyc == load_at) begin
        out_port = 8'hFF; load = 1'b1;
      end
      if (cyc == rst_at) rst = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      cyc++;
    end
    low = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== 1'b1 || txrdy !== 1'b1) begin
        failures++;
        $display("FAIL reset_hold: tx=%b txrdy=%b want 1 1", tx, txrdy);
      end
    end
    rst = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      checks++;
      if (tx !== 1'b1 || txrdy !== 1'b1) begin
        failures++;
        $display("FAIL reset_idle: tx=%b txrdy=%b want 1 1", tx, txrdy);
      end
    end
  endtask

  task automatic test_frame(input string name, input logic [7:0] d, input logic e,
                            input logic p, input logic o, input logic [10:0] expv);
    logic [10:0] bits;
    logic [10:0] want;
    int          low;
    logic        tx_e1;
    exp_q.push_back(expv);
    run_frame(d, e, p, o, -1, -1, bits, low, tx_e1);
    want = exp_q.pop_front();
    checks++;
    if (bits !== want) begin
      failures++;
      $display("FAIL %s_bits: got %b want %b (index 10..0)", name, bits, want);
    end
    checks++;
    if (low != 45) begin
      failures++;
      $display("FAIL %s_txrdy_low: got %0d want 45", name, low);
    end
    checks++;
    if (tx_e1 !== 1'b0) begin
      failures++;
      $display("FAIL %s_start_e1: tx=%b want 0", name, tx_e1);
    end
    checks++;
    if (tx !== 1'b1 || txrdy !== 1'b1) begin
      failures++;
      $display("FAIL %s_end_idle: tx=%b txrdy=%b want 1 1", name, tx, txrdy);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] bits;
    logic [10:0] want;
    int          low;
    logic        tx_e1;
    exp_q.push_back(11'b11010101010);
    run_frame(8'h55, 1'b1, 1'b0, 1'b0, 10, -1, bits, low, tx_e1);
    want = exp_q.pop_front();
    checks++;
    if (bits !== want) begin
      failures++;
      $display("FAIL b2b_ignored_load_bits: got %b want %b", bits, want);
    end
    checks++;
    if (low != 45) begin
      failures++;
      $display("FAIL b2b_ignored_load_low: got %0d want 45", low);
    end
    // Second load lands in the first ready cycle.
    exp_q.push_back(11'b11111111110);
    run_frame(8'hFF, 1'b1, 1'b0, 1'b0, -1, -1, bits, low, tx_e1);
    want = exp_q.pop_front();
    checks++;
    if (tx_e1 !== 1'b0) begin
      failures++;
      $display("FAIL b2b_start: tx=%b want 0", tx_e1);
    end
    checks++;
    if (bits !== want) begin
      failures++;
      $display("FAIL b2b_ff_bits: got %b want %b", bits, want);
    end
    checks++;
    if (low != 45) begin
      failures++;
      $display("FAIL b2b_ff_low: got %0d want 45", low);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] bits;
    logic [10:0] want;
    int          low;
    logic        tx_e1;
    run_frame(8'h55, 1'b1, 1'b0, 1'b0, -1, 20, bits, low, tx_e1);
    checks++;
    if (low != 21) begin
      failures++;
      $display("FAIL rstmid_abort_cycle: got %0d want 21", low);
    end
    checks++;
    if (tx !== 1'b1 || txrdy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_outputs: tx=%b txrdy=%b want 1 1", tx, txrdy);
    end
    rst = 1'b0;
    exp_q.push_back(11'b11000011110);
    run_frame(8'h0F, 1'b1, 1'b0, 1'b0, -1, -1, bits, low, tx_e1);
    want = exp_q.pop_front();
    checks++;
    if (bits !== want || tx_e1 !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_next_frame: got %b start=%b want %b start=0", bits, tx_e1, want);
    end
    checks++;
    if (low != 45) begin
      failures++;
      $display("FAIL rstmid_next_low: got %0d want 45", low);
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; load = 1'b0;
    out_port = 8'h00; eight = 1'b1; pen = 1'b0; ohel = 1'b0;
    checks = 0; failures = 0;
    test_reset();
    test_frame("f55", 8'h55, 1'b1, 1'b0, 1'b0, 11'b11010101010);
    test_frame("fa3_even", 8'hA3, 1'b1, 1'b1, 1'b0, 11'b10101000110);
    test_frame("f41_odd7", 8'h41, 1'b0, 1'b1, 1'b1, 11'b11110000010);
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
